// File: rtl/pg_aggregator.sv
// pg_aggregator: multi-channel power-good qualifier and aggregator.
// Each raw power-good input is synchronised (2 flops) and debounced into a
// per-channel qualified flag pg_ch_o. A supervisory FSM combines the unmasked
// channels into pg_all_o and latches the channels that dropped while GOOD.
//
// Optional build macro: PG_FALL_FILTER_EN
//   When defined, a channel clears only after FALL_CYCLES consecutive
//   synced-low samples. Shorter lows are ignored, and the rise counter holds
//   its value during them. When undefined, the first synced-low sample clears
//   the channel and FALL_CYCLES is unused.
//
// state | meaning
// OFF   | supervisor disabled, pg_all low
// QUAL  | enabled, waiting for every unmasked channel to qualify
// GOOD  | all unmasked channels qualified, pg_all high
// FAULT | an unmasked channel dropped while GOOD; held until clr_fault_i
module pg_aggregator #(
  parameter int N_CH        = 4,
  parameter int DEB_W       = 8,
  parameter int DEB_CYCLES  = 100,
  parameter int FALL_CYCLES = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [N_CH-1:0] ch_mask_i,
  input  logic [N_CH-1:0] pg_raw_i,
  input  logic            clr_fault_i,
  output logic [N_CH-1:0] pg_ch_o,
  output logic            pg_all_o,
  output logic            fault_o,
  output logic [N_CH-1:0] fault_vec_o,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_QUAL  = 2'd1,
    ST_GOOD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES);

  // Elaboration-time parameter range checks.
  if (DEB_CYCLES < 1 || DEB_CYCLES > (2**DEB_W - 1)) begin : g_bad_deb
    $error("pg_aggregator: DEB_CYCLES out of range");
  end
  if (FALL_CYCLES < 1) begin : g_bad_fall
    $error("pg_aggregator: FALL_CYCLES must be >= 1");
  end

  logic [N_CH-1:0]  sync1_q, sync2_q;
  logic [DEB_W-1:0] deb_cnt_q [N_CH];
  logic [DEB_W-1:0] deb_cnt_d [N_CH];
  logic [N_CH-1:0]  pg_ch_q, pg_ch_d;
`ifdef PG_FALL_FILTER_EN
  localparam int FW = (FALL_CYCLES < 2) ? 1 : $clog2(FALL_CYCLES + 1);
  localparam logic [FW-1:0] FALL_MAX = FW'(FALL_CYCLES);
  logic [FW-1:0]    fall_cnt_q [N_CH];
  logic [FW-1:0]    fall_cnt_d [N_CH];
`endif

  state_t           state_q, state_d;
  logic [N_CH-1:0]  fault_vec_q, fault_vec_d;
  logic             pg_all_q, fault_q;
  logic             ok;
  logic [N_CH-1:0]  drop;

  // Per-channel debounce next-state: saturating rise counter, fast or filtered fall.
  always_comb begin
    pg_ch_d = pg_ch_q;
    for (int i = 0; i < N_CH; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
`ifdef PG_FALL_FILTER_EN
      fall_cnt_d[i] = fall_cnt_q[i];
`endif
      if (sync2_q[i]) begin
`ifdef PG_FALL_FILTER_EN
        fall_cnt_d[i] = '0;
`endif
        if (deb_cnt_q[i] != DEB_MAX) deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        pg_ch_d[i] = (deb_cnt_d[i] == DEB_MAX);
      end else begin
`ifdef PG_FALL_FILTER_EN
        if (fall_cnt_q[i] != FALL_MAX) fall_cnt_d[i] = fall_cnt_q[i] + 1'b1;
        if (fall_cnt_d[i] == FALL_MAX) begin
          deb_cnt_d[i] = '0;
          pg_ch_d[i]   = 1'b0;
        end
`else
        deb_cnt_d[i] = '0;
        pg_ch_d[i]   = 1'b0;
`endif
      end
    end
  end

  // Synchroniser, debounce counters and qualified flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pg_ch_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        deb_cnt_q[i] <= '0;
`ifdef PG_FALL_FILTER_EN
        fall_cnt_q[i] <= '0;
`endif
      end
    end else begin
      sync1_q <= pg_raw_i;
      sync2_q <= sync1_q;
      pg_ch_q <= pg_ch_d;
      for (int i = 0; i < N_CH; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
`ifdef PG_FALL_FILTER_EN
        fall_cnt_q[i] <= fall_cnt_d[i];
`endif
      end
    end
  end

  assign ok   = &(pg_ch_q | ~ch_mask_i);
  assign drop = ch_mask_i & ~pg_ch_q;

  // Supervisor next-state; mask is live, clear beats drop, disable beats drop.
  always_comb begin
    state_d     = state_q;
    fault_vec_d = fault_vec_q;
    case (state_q)
      ST_OFF:  if (en_i) state_d = ST_QUAL;
      ST_QUAL: begin
        if (!en_i)   state_d = ST_OFF;
        else if (ok) state_d = ST_GOOD;
      end
      ST_GOOD: begin
        if (!en_i) begin
          state_d = ST_OFF;
        end else if (drop != '0) begin
          state_d     = ST_FAULT;
          fault_vec_d = fault_vec_q | drop;
        end
      end
      ST_FAULT: begin
        if (clr_fault_i) begin
          state_d     = en_i ? ST_QUAL : ST_OFF;
          fault_vec_d = '0;
        end else begin
          fault_vec_d = fault_vec_q | drop;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Supervisor registers; pg_all and fault are registered from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_OFF;
      fault_vec_q <= '0;
      pg_all_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fault_vec_q <= fault_vec_d;
      pg_all_q    <= (state_d == ST_GOOD);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign pg_ch_o     = pg_ch_q;
  assign pg_all_o    = pg_all_q;
  assign fault_o     = fault_q;
  assign fault_vec_o = fault_vec_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pg_aggregator.sv
// Directed bench for pg_aggregator: N_CH=2, DEB_CYCLES=4, FALL_CYCLES=3.
// A per-cycle vector table covers bring-up, fault/clear, masking and disable;
// hand-written sequences cover reset, the short glitch and reset mid-run.
module tb_pg_aggregator;
  localparam int N_CH        = 2;
  localparam int DEB_W       = 8;
  localparam int DEB_CYCLES  = 4;
  localparam int FALL_CYCLES = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N_CH-1:0] ch_mask;
  logic [N_CH-1:0] pg_raw;
  logic            clr_fault;
  logic [N_CH-1:0] pg_ch;
  logic            pg_all;
  logic            fault;
  logic [N_CH-1:0] fault_vec;
  logic [1:0]      state;

  pg_aggregator #(
    .N_CH(N_CH), .DEB_W(DEB_W), .DEB_CYCLES(DEB_CYCLES), .FALL_CYCLES(FALL_CYCLES)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .ch_mask_i(ch_mask), .pg_raw_i(pg_raw),
    .clr_fault_i(clr_fault), .pg_ch_o(pg_ch), .pg_all_o(pg_all), .fault_o(fault),
    .fault_vec_o(fault_vec), .state_o(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] mask;
    logic [1:0] raw;
    logic       clr;
    logic [1:0] e_pgch;
    logic       e_all;
    logic       e_fault;
    logic [1:0] e_fv;
    logic [1:0] e_st;
  } vec_t;

  vec_t vq[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, row, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int row, input logic [1:0] e_pgch,
                           input logic e_all, input logic e_fault, input logic [1:0] e_fv,
                           input logic [1:0] e_st);
    check({name, ".pg_ch"}, row, 32'(pg_ch), 32'(e_pgch));
    check({name, ".pg_all"}, row, 32'(pg_all), 32'(e_all));
    check({name, ".fault"}, row, 32'(fault), 32'(e_fault));
    check({name, ".fault_vec"}, row, 32'(fault_vec), 32'(e_fv));
    check({name, ".state"}, row, 32'(state), 32'(e_st));
  endtask

  task automatic add(input int reps, input logic v_en, input logic [1:0] v_mask,
                     input logic [1:0] v_raw, input logic v_clr, input logic [1:0] e_pgch,
                     input logic e_all, input logic e_fault, input logic [1:0] e_fv,
                     input logic [1:0] e_st);
    vec_t v;
    v.en = v_en; v.mask = v_mask; v.raw = v_raw; v.clr = v_clr;
    v.e_pgch = e_pgch; v.e_all = e_all; v.e_fault = e_fault; v.e_fv = e_fv; v.e_st = e_st;
    for (int r = 0; r < reps; r++) vq.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reps  en  mask   raw    clr | pg_ch  all flt fv     st
    // bring-up: pg_ch at step 6, GOOD at step 7
    add(5, 1, 2'b11, 2'b11, 0,  2'b00, 0, 0, 2'b00, 2'd1);
    add(1, 1, 2'b11, 2'b11, 0,  2'b11, 0, 0, 2'b00, 2'd1);
    add(2, 1, 2'b11, 2'b11, 0,  2'b11, 1, 0, 2'b00, 2'd2);
    // ch1 falls: pg_ch[1] low 3 clocks later, FAULT one clock after
    add(2, 1, 2'b11, 2'b01, 0,  2'b11, 1, 0, 2'b00, 2'd2);
    add(1, 1, 2'b11, 2'b01, 0,  2'b01, 1, 0, 2'b00, 2'd2);
    add(1, 1, 2'b11, 2'b01, 0,  2'b01, 0, 1, 2'b10, 2'd3);
    // en ignored in FAULT
    add(1, 0, 2'b11, 2'b01, 0,  2'b01, 0, 1, 2'b10, 2'd3);
    // clear beats the ongoing drop -> QUAL; clear outside FAULT does nothing
    add(1, 1, 2'b11, 2'b01, 1,  2'b01, 0, 0, 2'b00, 2'd1);
    add(1, 1, 2'b11, 2'b01, 1,  2'b01, 0, 0, 2'b00, 2'd1);
    // mask ch1 -> GOOD; ch1 toggling is ignored
    add(1, 1, 2'b01, 2'b01, 0,  2'b01, 1, 0, 2'b00, 2'd2);
    add(2, 1, 2'b01, 2'b11, 0,  2'b01, 1, 0, 2'b00, 2'd2);
    add(1, 1, 2'b01, 2'b01, 0,  2'b01, 1, 0, 2'b00, 2'd2);
    add(1, 1, 2'b01, 2'b11, 0,  2'b01, 1, 0, 2'b00, 2'd2);
    add(2, 1, 2'b01, 2'b01, 0,  2'b01, 1, 0, 2'b00, 2'd2);
    // unmask non-qualified ch1 while GOOD -> FAULT
    add(1, 1, 2'b11, 2'b01, 0,  2'b01, 0, 1, 2'b10, 2'd3);
    // clear and requalify ch1
    add(1, 1, 2'b11, 2'b11, 1,  2'b01, 0, 0, 2'b00, 2'd1);
    add(4, 1, 2'b11, 2'b11, 0,  2'b01, 0, 0, 2'b00, 2'd1);
    add(1, 1, 2'b11, 2'b11, 0,  2'b11, 0, 0, 2'b00, 2'd1);
    add(1, 1, 2'b11, 2'b11, 0,  2'b11, 1, 0, 2'b00, 2'd2);
    // disable with all rails dropping: orderly OFF, no fault
    add(2, 0, 2'b11, 2'b00, 0,  2'b11, 0, 0, 2'b00, 2'd0);
    add(1, 0, 2'b11, 2'b00, 0,  2'b00, 0, 0, 2'b00, 2'd0);

    // reset with rails already high
    rst = 1'b1; en = 1'b0; ch_mask = 2'b11; pg_raw = 2'b11; clr_fault = 1'b0;
    tick();
    check_all("reset_c1", 0, 2'b00, 0, 0, 2'b00, 2'd0);
    tick();
    check_all("reset_c2", 0, 2'b00, 0, 0, 2'b00, 2'd0);
    rst = 1'b0;
    tick();
    check_all("reset_release", 0, 2'b00, 0, 0, 2'b00, 2'd0);
    pg_raw = 2'b00;
    repeat (8) tick();

`ifndef PG_FALL_FILTER_EN
    for (int i = 0; i < vq.size(); i++) begin
      en = vq[i].en; ch_mask = vq[i].mask; pg_raw = vq[i].raw; clr_fault = vq[i].clr;
      tick();
      check_all("vec", i + 1, vq[i].e_pgch, vq[i].e_all, vq[i].e_fault, vq[i].e_fv,
                vq[i].e_st);
    end
    clr_fault = 1'b0;
`endif

    // bring-up for the glitch test: GOOD exactly 7 clocks after rails rise
    en = 1'b1; ch_mask = 2'b11; pg_raw = 2'b11; clr_fault = 1'b0;
    repeat (7) tick();
    check_all("glitch_bringup", 0, 2'b11, 1, 0, 2'b00, 2'd2);

    // 2-clock low pulse on ch0
    for (int g = 1; g <= 8; g++) begin
      pg_raw = (g <= 2) ? 2'b10 : 2'b11;
      tick();
`ifdef PG_FALL_FILTER_EN
      check("glitch.state", g, 32'(state), 32'd2);
      check("glitch.pg_all", g, 32'(pg_all), 32'd1);
`else
      check("glitch.state", g, 32'(state), (g >= 4) ? 32'd3 : 32'd2);
      check("glitch.pg_all", g, 32'(pg_all), (g >= 4) ? 32'd0 : 32'd1);
`endif
    end
`ifdef PG_FALL_FILTER_EN
    check("glitch.fault_vec", 9, 32'(fault_vec), 32'd0);
`else
    check("glitch.fault_vec", 9, 32'(fault_vec), 32'd1);
    check("glitch.fault", 9, 32'(fault), 32'd1);
`endif

    // reset mid-operation clears everything on the next edge
    rst = 1'b1;
    tick();
    check_all("reset_midrun", 0, 2'b00, 0, 0, 2'b00, 2'd0);
    rst = 1'b0;
    en = 1'b0;
    tick();
    check_all("reset_midrun_release", 0, 2'b00, 0, 0, 2'b00, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
